// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: in-order allocate at tail, out-of-order completion
// from the CDB, in-order retire at head with mispredict detection and operand lookup.
module reorder_buffer #(
    parameter int ROB_SIZE = 16,
    parameter int TAG_W    = 4
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             rdy_in,

    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    input  logic             issue_has_rd,
    input  logic             issue_is_branch,
    input  logic             issue_pred_taken,
    input  logic [31:0]      issue_pc,
    output logic [TAG_W-1:0] issue_tag,
    output logic             rob_full,

    input  logic [TAG_W-1:0] q1_tag,
    input  logic [TAG_W-1:0] q2_tag,
    output logic             q1_ready,
    output logic             q2_ready,
    output logic [31:0]      q1_val,
    output logic [31:0]      q2_val,

    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_val,
    input  logic             cdb_taken,
    input  logic [31:0]      cdb_target,

    output logic             commit_valid,
    output logic [4:0]       commit_rd,
    output logic [31:0]      commit_val,
    output logic [TAG_W-1:0] commit_tag,
    output logic             flush,
    output logic [31:0]      flush_pc
);

    localparam logic [TAG_W:0]   FULL_COUNT = (TAG_W+1)'(ROB_SIZE);
    localparam logic [TAG_W-1:0] TAG_ONE    = TAG_W'(1);
    localparam logic [TAG_W:0]   CNT_ONE    = (TAG_W+1)'(1);

    // Per-entry control state (reset) and payload (not reset).
    logic [ROB_SIZE-1:0] r_busy;
    logic [ROB_SIZE-1:0] r_ready;
    logic [ROB_SIZE-1:0] r_has_rd;
    logic [ROB_SIZE-1:0] r_is_branch;
    logic [ROB_SIZE-1:0] r_pred;
    logic [ROB_SIZE-1:0] r_taken;
    logic [4:0]          r_rd     [ROB_SIZE];
    logic [31:0]         r_val    [ROB_SIZE];
    logic [31:0]         r_pc     [ROB_SIZE];
    logic [31:0]         r_target [ROB_SIZE];

    logic [TAG_W-1:0]    r_head;
    logic [TAG_W-1:0]    r_tail;
    logic [TAG_W:0]      r_count;

    logic                r_commit_valid;
    logic [4:0]          r_commit_rd;
    logic [31:0]         r_commit_val;
    logic [TAG_W-1:0]    r_commit_tag;
    logic                r_flush;
    logic [31:0]         r_flush_pc;

    logic                w_retire;
    logic                w_flush_now;
    logic                w_issue;
    logic                w_wb;

    assign rob_full  = (r_count == FULL_COUNT);
    assign issue_tag = r_tail;

    // Retire looks only at registered state; a same-cycle CDB result waits one cycle.
    assign w_retire    = rdy_in && r_busy[r_head] && r_ready[r_head];
    assign w_flush_now = w_retire && r_is_branch[r_head] &&
                         (r_taken[r_head] != r_pred[r_head]);
    assign w_issue     = rdy_in && issue_valid && !rob_full && !w_flush_now;
    assign w_wb        = rdy_in && cdb_valid && r_busy[cdb_tag] && !w_flush_now;

    assign commit_valid = r_commit_valid;
    assign commit_rd    = r_commit_rd;
    assign commit_val   = r_commit_val;
    assign commit_tag   = r_commit_tag;
    assign flush        = r_flush;
    assign flush_pc     = r_flush_pc;

    // NOTE: all sequential state uses non-blocking assignments so every read in this
    // block sees the pre-edge value, independent of statement order within the block.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_busy         <= '0;
            r_ready        <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_valid <= 1'b0;
            r_commit_rd    <= '0;
            r_commit_val   <= '0;
            r_commit_tag   <= '0;
            r_flush        <= 1'b0;
            r_flush_pc     <= '0;
        end else begin
            r_commit_valid <= 1'b0;
            r_flush        <= 1'b0;

            if (w_flush_now) begin
                r_busy  <= '0;
                r_ready <= '0;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_wb) begin
                    r_ready[cdb_tag] <= 1'b1;
                end
                if (w_issue) begin
                    r_busy[r_tail]  <= 1'b1;
                    r_ready[r_tail] <= 1'b0;
                    r_tail          <= r_tail + TAG_ONE;
                end
                // Placed after the writeback so retiring the head always frees it.
                if (w_retire) begin
                    r_busy[r_head]  <= 1'b0;
                    r_ready[r_head] <= 1'b0;
                    r_head          <= r_head + TAG_ONE;
                end
                if (w_issue && !w_retire) begin
                    r_count <= r_count + CNT_ONE;
                end else if (!w_issue && w_retire) begin
                    r_count <= r_count - CNT_ONE;
                end
            end

            if (w_retire) begin
                r_commit_valid <= r_has_rd[r_head] && (r_rd[r_head] != 5'd0);
                r_commit_rd    <= r_rd[r_head];
                r_commit_val   <= r_val[r_head];
                r_commit_tag   <= r_head;
                if (w_flush_now) begin
                    r_flush    <= 1'b1;
                    r_flush_pc <= r_taken[r_head] ? r_target[r_head]
                                                  : r_pc[r_head] + 32'd4;
                end
            end
        end
    end

    // NOTE: payload storage has no reset; busy/ready gate every use, so stale contents
    // are never observed and the array maps onto plain flops or RAM without reset muxes.
    always_ff @(posedge clk_in) begin
        if (w_issue) begin
            r_rd[r_tail]        <= issue_rd;
            r_has_rd[r_tail]    <= issue_has_rd;
            r_is_branch[r_tail] <= issue_is_branch;
            r_pred[r_tail]      <= issue_pred_taken;
            r_pc[r_tail]        <= issue_pc;
            r_val[r_tail]       <= '0;
        end
        if (w_wb) begin
            r_val[cdb_tag]    <= cdb_val;
            r_taken[cdb_tag]  <= cdb_taken;
            r_target[cdb_tag] <= cdb_target;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path
    // through the if-tree leaves it unassigned and infers a latch.
    always_comb begin
        q1_ready = 1'b0;
        q1_val   = '0;
        if (r_busy[q1_tag]) begin
            if (cdb_valid && (cdb_tag == q1_tag)) begin
                q1_ready = 1'b1;
                q1_val   = cdb_val;
            end else begin
                q1_ready = r_ready[q1_tag];
                q1_val   = r_val[q1_tag];
            end
        end
    end

    always_comb begin
        q2_ready = 1'b0;
        q2_val   = '0;
        if (r_busy[q2_tag]) begin
            if (cdb_valid && (cdb_tag == q2_tag)) begin
                q2_ready = 1'b1;
                q2_val   = cdb_val;
            end else begin
                q2_ready = r_ready[q2_tag];
                q2_val   = r_val[q2_tag];
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a commit/flush scoreboard filled as stimulus
// is driven and drained by a negedge monitor, plus directed checks on lookup and pointers.
module tb_reorder_buffer;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        logic [3:0]  tag;
    } commit_t;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        rdy_in;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_has_rd;
    logic        issue_is_branch;
    logic        issue_pred_taken;
    logic [31:0] issue_pc;
    logic [3:0]  issue_tag;
    logic        rob_full;
    logic [3:0]  q1_tag;
    logic [3:0]  q2_tag;
    logic        q1_ready;
    logic        q2_ready;
    logic [31:0] q1_val;
    logic [31:0] q2_val;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_val;
    logic        cdb_taken;
    logic [31:0] cdb_target;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val;
    logic [3:0]  commit_tag;
    logic        flush;
    logic [31:0] flush_pc;

    int          n_checks = 0;
    int          n_fail   = 0;
    commit_t     exp_q[$];
    logic [31:0] flush_q[$];
    commit_t     mon_e;
    logic [31:0] mon_pc;

    reorder_buffer #(.ROB_SIZE(16), .TAG_W(4)) dut (
        .clk_in           (clk_in),
        .rst_n            (rst_n),
        .rdy_in           (rdy_in),
        .issue_valid      (issue_valid),
        .issue_rd         (issue_rd),
        .issue_has_rd     (issue_has_rd),
        .issue_is_branch  (issue_is_branch),
        .issue_pred_taken (issue_pred_taken),
        .issue_pc         (issue_pc),
        .issue_tag        (issue_tag),
        .rob_full         (rob_full),
        .q1_tag           (q1_tag),
        .q2_tag           (q2_tag),
        .q1_ready         (q1_ready),
        .q2_ready         (q2_ready),
        .q1_val           (q1_val),
        .q2_val           (q2_val),
        .cdb_valid        (cdb_valid),
        .cdb_tag          (cdb_tag),
        .cdb_val          (cdb_val),
        .cdb_taken        (cdb_taken),
        .cdb_target       (cdb_target),
        .commit_valid     (commit_valid),
        .commit_rd        (commit_rd),
        .commit_val       (commit_val),
        .commit_tag       (commit_tag),
        .flush            (flush),
        .flush_pc         (flush_pc)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_commit_valid"}, 32'(commit_valid), 32'd0);
        check({tag, "_commit_rd"},    32'(commit_rd),    32'd0);
        check({tag, "_commit_val"},   commit_val,        32'd0);
        check({tag, "_commit_tag"},   32'(commit_tag),   32'd0);
        check({tag, "_flush"},        32'(flush),        32'd0);
        check({tag, "_flush_pc"},     flush_pc,          32'd0);
        check({tag, "_issue_tag"},    32'(issue_tag),    32'd0);
        check({tag, "_rob_full"},     32'(rob_full),     32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset");
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        rst_n = 1'b1;
    endtask

    // Drives one issue for a cycle; exp_tag is the tail the bench expects to be assigned.
    task automatic do_issue(input logic [3:0] exp_tag, input logic [4:0] rd, input logic has_rd,
                            input logic br, input logic pred, input logic [31:0] pc,
                            input logic push, input logic [31:0] val);
        commit_t e;
        check("issue_tag", 32'(issue_tag), 32'(exp_tag));
        issue_valid      = 1'b1;
        issue_rd         = rd;
        issue_has_rd     = has_rd;
        issue_is_branch  = br;
        issue_pred_taken = pred;
        issue_pc         = pc;
        if (push) begin
            e.rd  = rd;
            e.val = val;
            e.tag = exp_tag;
            exp_q.push_back(e);
        end
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic do_cdb(input logic [3:0] tag, input logic [31:0] val,
                          input logic taken, input logic [31:0] target);
        cdb_valid  = 1'b1;
        cdb_tag    = tag;
        cdb_val    = val;
        cdb_taken  = taken;
        cdb_target = target;
        tick();
        cdb_valid = 1'b0;
    endtask

    // Scoreboard side: every commit and flush the DUT produces must match the queue head.
    always @(negedge clk_in) begin
        if (rst_n) begin
            if (commit_valid) begin
                if (exp_q.size() == 0) begin
                    check("commit_spurious", 32'(commit_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("commit_rd",  32'(commit_rd),  32'(mon_e.rd));
                    check("commit_val", commit_val,      mon_e.val);
                    check("commit_tag", 32'(commit_tag), 32'(mon_e.tag));
                end
            end
            if (flush) begin
                if (flush_q.size() == 0) begin
                    check("flush_spurious", 32'(flush), 32'd0);
                end else begin
                    mon_pc = flush_q.pop_front();
                    check("flush_pc", flush_pc, mon_pc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rdy_in           = 1'b1;
        issue_valid      = 1'b0;
        issue_rd         = '0;
        issue_has_rd     = 1'b0;
        issue_is_branch  = 1'b0;
        issue_pred_taken = 1'b0;
        issue_pc         = '0;
        q1_tag           = '0;
        q2_tag           = '0;
        cdb_valid        = 1'b0;
        cdb_tag          = '0;
        cdb_val          = '0;
        cdb_taken        = 1'b0;
        cdb_target       = '0;

        // Basic issue, lookup bypass and in-order commit.
        do_reset();
        do_issue(4'd0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h11);
        do_issue(4'd1, 5'd2, 1'b1, 1'b0, 1'b0, 32'h4, 1'b1, 32'h22);
        do_issue(4'd2, 5'd3, 1'b1, 1'b0, 1'b0, 32'h8, 1'b1, 32'h33);
        check("tail_after_3", 32'(issue_tag), 32'd3);
        cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_val = 32'h22; cdb_taken = 1'b0;
        q1_tag = 4'd1; q2_tag = 4'd2;
        #1;
        check("q1_bypass_ready", 32'(q1_ready), 32'd1);
        check("q1_bypass_val",   q1_val,        32'h22);
        check("q2_not_ready",    32'(q2_ready), 32'd0);
        tick();
        cdb_valid = 1'b0;
        #1;
        check("q1_stored_ready", 32'(q1_ready),     32'd1);
        check("q1_stored_val",   q1_val,            32'h22);
        check("no_commit_yet",   32'(commit_valid), 32'd0);
        do_cdb(4'd0, 32'h11, 1'b0, 32'h0);
        check("commit_latency", 32'(commit_valid), 32'd0);
        tick();
        check("commit0_visible", 32'(commit_valid), 32'd1);
        do_cdb(4'd2, 32'h33, 1'b0, 32'h0);
        repeat (4) tick();
        check("t1_drained", 32'(exp_q.size()), 32'd0);

        // Fill to 16, ignored 17th issue, tag reuse after one retire.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            do_issue(4'(i), 5'(i + 1), 1'b1, 1'b0, 1'b0, 32'(i * 4), 1'b1, 32'h1000 + 32'(i));
        end
        check("full_after_16", 32'(rob_full),  32'd1);
        check("tail_wrapped",  32'(issue_tag), 32'd0);
        do_issue(4'd0, 5'd30, 1'b1, 1'b0, 1'b0, 32'h40, 1'b0, 32'h0);
        check("full_ignores_issue", 32'(issue_tag), 32'd0);
        check("still_full",         32'(rob_full),  32'd1);
        do_cdb(4'd0, 32'h1000, 1'b0, 32'h0);
        check("full_until_retire", 32'(rob_full), 32'd1);
        tick();
        check("not_full_after_retire", 32'(rob_full), 32'd0);
        do_issue(4'd0, 5'd20, 1'b1, 1'b0, 1'b0, 32'h80, 1'b1, 32'h2000);
        check("full_again", 32'(rob_full),  32'd1);
        check("tail_at_1",  32'(issue_tag), 32'd1);
        for (int t = 1; t < 16; t++) begin
            do_cdb(4'(t), 32'h1000 + 32'(t), 1'b0, 32'h0);
        end
        do_cdb(4'd0, 32'h2000, 1'b0, 32'h0);
        repeat (4) tick();
        check("t2_drained", 32'(exp_q.size()), 32'd0);

        // Taken mispredict: flush, younger entries discarded, retire-cycle issue dropped.
        do_reset();
        do_issue(4'd0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0);
        do_issue(4'd1, 5'd5, 1'b1, 1'b0, 1'b0, 32'h104, 1'b0, 32'h0);
        do_issue(4'd2, 5'd6, 1'b1, 1'b0, 1'b0, 32'h108, 1'b0, 32'h0);
        do_cdb(4'd1, 32'h55, 1'b0, 32'h0);
        flush_q.push_back(32'h200);
        do_cdb(4'd0, 32'h0, 1'b1, 32'h200);
        issue_valid = 1'b1; issue_rd = 5'd7; issue_has_rd = 1'b1;
        issue_is_branch = 1'b0; issue_pc = 32'h10c;
        tick();
        issue_valid = 1'b0;
        check("flush_pulse",        32'(flush),        32'd1);
        check("flush_clears_tail",  32'(issue_tag),    32'd0);
        check("branch_no_commit",   32'(commit_valid), 32'd0);
        check("flush_not_full",     32'(rob_full),     32'd0);
        q1_tag = 4'd1;
        #1;
        check("young_gone_ready", 32'(q1_ready), 32'd0);
        check("young_gone_val",   q1_val,        32'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_val = 32'h77;
        #1;
        check("cdb_to_free_tag", 32'(q1_ready), 32'd0);
        cdb_valid = 1'b0;
        tick();
        check("flush_one_cycle", 32'(flush), 32'd0);

        // Not-taken mispredict (pc+4 across a boundary), then a correct prediction.
        do_issue(4'd0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h1FC, 1'b0, 32'h0);
        flush_q.push_back(32'h200);
        do_cdb(4'd0, 32'h0, 1'b0, 32'h999);
        tick();
        check("nt_flush_pulse", 32'(flush), 32'd1);
        tick();
        do_issue(4'd0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0);
        do_cdb(4'd0, 32'h0, 1'b1, 32'h400);
        tick();
        check("correct_pred_no_flush",  32'(flush),        32'd0);
        check("correct_pred_no_commit", 32'(commit_valid), 32'd0);
        check("correct_pred_keeps_ptr", 32'(issue_tag),    32'd1);
        tick();
        check("t3_flushes_seen", 32'(flush_q.size()), 32'd0);

        // Same-cycle lookup bypass on tag 5, rd=0 retire, then a rdy_in freeze.
        do_reset();
        do_issue(4'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int t = 1; t < 5; t++) begin
            do_issue(4'(t), 5'(t), 1'b1, 1'b0, 1'b0, 32'(t * 4), 1'b1, 32'h40 + 32'(t));
        end
        do_issue(4'd5, 5'd5, 1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 32'hDEAD);
        cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_val = 32'hDEAD; cdb_taken = 1'b0;
        q2_tag = 4'd5; q1_tag = 4'd4;
        #1;
        check("q2_bypass_ready", 32'(q2_ready), 32'd1);
        check("q2_bypass_val",   q2_val,        32'hDEAD);
        check("q1_pending",      32'(q1_ready), 32'd0);
        tick();
        cdb_valid = 1'b0;
        do_cdb(4'd0, 32'h5, 1'b0, 32'h0);
        tick();
        check("rd0_no_commit", 32'(commit_valid), 32'd0);
        for (int t = 1; t < 5; t++) begin
            do_cdb(4'(t), 32'h40 + 32'(t), 1'b0, 32'h0);
        end
        rdy_in = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd8; issue_has_rd = 1'b1; issue_pc = 32'h18;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("frozen_no_commit", 32'(commit_valid), 32'd0);
            check("frozen_tail",      32'(issue_tag),    32'd6);
        end
        rdy_in = 1'b1;
        issue_valid = 1'b0;
        tick();
        check("resume_commit",    32'(commit_valid), 32'd1);
        check("resume_commit_rd", 32'(commit_rd),    32'd4);
        repeat (3) tick();
        check("t5_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset while a commit is on the outputs.
        do_issue(4'd6, 5'd9,  1'b1, 1'b0, 1'b0, 32'h18, 1'b1, 32'h99);
        do_issue(4'd7, 5'd10, 1'b1, 1'b0, 1'b0, 32'h1c, 1'b0, 32'h0);
        do_cdb(4'd6, 32'h99, 1'b0, 32'h0);
        tick();
        check("pre_reset_commit", 32'(commit_valid), 32'd1);
        @(negedge clk_in);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        @(posedge clk_in);
        #1;
        rst_n = 1'b1;
        q1_tag = 4'd7;
        #1;
        check("reset_discards_entry", 32'(q1_ready), 32'd0);
        tick();
        check("final_commits_empty", 32'(exp_q.size()),   32'd0);
        check("final_flushes_empty", 32'(flush_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- 16-entry circular reorder buffer (ROB) for the Tomasulo RISC-V core.
- Issue allocates one entry per instruction. The returned tag is the ROB index that the reservation station carries with the operation.
- Entries complete from CDB broadcasts (ALU/LSB results) and retire in order to the register file.
- Detects branch mispredicts at commit and broadcasts a pipeline flush.
- Provides operand lookup so the reservation station can obtain values for renamed registers.

Parameters:
- ROB_SIZE, 16, number of entries (power of two).
- TAG_W, 4, tag width, log2(ROB_SIZE).

Ports:
- clk_in  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rdy_in  input  1  global enable; 0 freezes all state.
- issue_valid  input  1  allocate request.
- issue_rd  input  5  destination register.
- issue_has_rd  input  1  instruction writes rd.
- issue_is_branch  input  1  conditional branch.
- issue_pred_taken  input  1  predicted direction.
- issue_pc  input  32  instruction PC.
- issue_tag  output  TAG_W  tag assigned on this cycle's issue (current tail).
- rob_full  output  1  no free entry.
- q1_tag, q2_tag  input  TAG_W  operand lookup tags.
- q1_ready, q2_ready  output  1  value available.
- q1_val, q2_val  output  32  looked-up value.
- cdb_valid  input  1  result broadcast.
- cdb_tag  input  TAG_W  producing entry.
- cdb_val  input  32  result value.
- cdb_taken  input  1  actual branch outcome.
- cdb_target  input  32  branch target when taken.
- commit_valid  output  1  register write this cycle.
- commit_rd  output  5  register index.
- commit_val  output  32  value.
- commit_tag  output  TAG_W  retiring tag, lets the regfile clear its rename.
- flush  output  1  mispredict flush pulse.
- flush_pc  output  32  redirect PC.

Behaviour:
- Per-entry state: busy, ready, has_rd, is_branch, pred, taken, rd, val, pc, target.
- Pointers: head, tail (TAG_W bits, wrap modulo ROB_SIZE); count (TAG_W+1 bits).
- Reset (asynchronous, rst_n=0):
  - all busy/ready cleared; head=tail=count=0.
  - commit_valid=0, commit_rd=0, commit_val=0, commit_tag=0, flush=0, flush_pc=0.
  - issue_tag=0, rob_full=0.
  - Reset asserted mid-operation discards all in-flight entries immediately.
- rob_full = (count==ROB_SIZE); issue_tag = tail. Both are combinational from registers.
- Issue: accepted iff issue_valid && !rob_full && !flush_now.
  - Writes the entry at tail with busy=1, ready=0.
  - tail+1, count+1.
  - Issue while full is ignored; no state change, no error.
- CDB writeback: if cdb_valid && busy[cdb_tag], set ready=1 and latch val, taken, target.
  - Broadcast to a non-busy tag is ignored.
  - Writeback to the tail entry being issued in the same cycle is ignored, because that entry is not yet busy.
- Commit: each cycle, if busy[head] && ready[head] (registered state only; no CDB bypass):
  - Retires head; head+1, count-1.
  - Next cycle: commit_valid=1 iff has_rd && rd!=0, with commit_rd/val/tag from the entry.
  - Otherwise commit_valid=0. Commit outputs are registered, so latency is 1 cycle after ready is visible.
  - At most one retire per cycle.
- Mispredict: retiring entry has is_branch && taken!=pred.
  - flush_now is asserted combinationally in the retire cycle.
  - Next cycle: flush=1 for exactly one cycle, with flush_pc = taken ? target : pc+4 (32-bit wrap).
  - In the retire cycle, all busy/ready are cleared and head=tail=count=0 on the edge.
  - Same-cycle issue and CDB writes are discarded.
  - A correctly predicted branch retires with no flush and commit_valid=0.
- Simultaneous issue and retire: count unchanged; tail and head each advance.
- Operand lookup (combinational), for q = q1 or q2:
  - q_ready = ready[q_tag] || (cdb_valid && cdb_tag==q_tag && busy[q_tag]).
  - q_val = matching CDB value if bypassing, otherwise val[q_tag].
  - Result for a non-busy tag: ready=0, val=0.
- rdy_in=0: no issue/writeback/retire accepted; pointers and entries hold; commit_valid=0 and flush=0 on the next edge.
- Wrap-around: tail/head roll from 15 to 0 with no gap; a full buffer holds 16 live entries.

Test Plan:
- Reset, then issue 3 ops (rd=1,2,3) → issue_tag 0,1,2 and count 3. CDB tag1 val=0x22 → q1_tag=1 gives q1_ready=1, q1_val=0x22, no commit. CDB tag0 val=0x11 → commit rd=1 val=0x11 tag=0, then rd=2 val=0x22 tag=1 on consecutive cycles.
- Issue 16 ops without writeback → rob_full=1, and a 17th issue is ignored (tail stays 0). Retire head, then issue → tag 0 is reused and full status is correct.
- Branch at tag0, pred=0, pc=0x100; CDB taken=1, target=0x200 → flush=1 for one cycle with flush_pc=0x200. After the flush, count=0 and issue_tag=0, the younger tags are gone, and an issue in the retire cycle is dropped.
- Branch pred=1, pc=0x1FC, CDB taken=0 → flush_pc=0x200. Branch pred=taken → no flush, commit_valid=0.
- Query tag5 in the same cycle as CDB tag5 val=0xDEAD → q_ready=1, q_val=0xDEAD. Op with rd=0 retiring → commit_valid=0 while head advances.
- rdy_in=0 for 3 cycles with a ready head → no commit and pointers frozen; the commit occurs 1 cycle after rdy_in returns to 1. rst_n pulsed low mid-stream → all outputs 0 asynchronously.
